// File: rtl/blob_tracker_pkg.sv
// Shared types and helpers for the blob extent tracker: FSM state encoding,
// width helpers and accumulator reset patterns.
package blob_tracker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DIV   = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Min trackers start high so the first hit always wins; max trackers start low.
    localparam logic [31:0] MIN_RST = 32'hFFFF_FFFF;
    localparam logic [31:0] MAX_RST = 32'h0000_0000;

    function automatic int cls_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int sum_w(input int coord_w, input int cnt_w);
        return coord_w + cnt_w;
    endfunction

endpackage

// File: rtl/blob_seq_divider.sv
// Restoring divider, one quotient bit per cycle; quotient only.
// 'len' selects how many dividend bits are significant (LSB-aligned), giving len cycles.
module blob_seq_divider #(
    parameter int DW = 29,
    parameter int VW = 19,
    parameter int LW = $clog2(DW + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          done,
    output logic [DW-1:0] quotient
);

    logic [VW-1:0] r_rem;
    logic [DW-1:0] r_quo;
    logic [LW-1:0] r_cnt;
    logic [VW:0]   w_shift;
    logic [VW-1:0] w_sub;
    logic          w_ge;

    assign w_shift  = {r_rem, r_quo[DW-1]};
    assign w_ge     = (w_shift >= {1'b0, divisor});
    // Remainder after a successful subtract is below divisor, so VW-bit wraparound is exact.
    assign w_sub    = w_shift[VW-1:0] - divisor;
    assign done     = (r_cnt == LW'(1));
    assign quotient = r_quo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
        end else if (start) begin
            r_rem <= '0;
            r_quo <= dividend << (LW'(DW) - len);
            r_cnt <= len;
        end else if (r_cnt != '0) begin
            r_rem <= w_ge ? w_sub : w_shift[VW-1:0];
            r_quo <= {r_quo[DW-2:0], w_ge};
            r_cnt <= r_cnt - LW'(1);
        end
    end

endmodule

// File: rtl/blob_extent_tracker.sv
// Per-class bounding box, pixel count and centroid of binarised objects per frame.
// Optional ROI gating when BLOB_TRACKER_ROI_EN is defined.
module blob_extent_tracker
    import blob_tracker_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int XW      = 10,
    parameter int YW      = 10,
    parameter int CNT_W   = 19,
    parameter int MIN_PIX = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
`ifdef BLOB_TRACKER_ROI_EN
    input  logic [XW-1:0]             roi_x0,
    input  logic [XW-1:0]             roi_x1,
    input  logic [YW-1:0]             roi_y0,
    input  logic [YW-1:0]             roi_y1,
`endif
    input  logic                      frame_start,
    input  logic                      pix_valid,
    input  logic                      pix_hit,
    input  logic [cls_w(NUM_CH)-1:0]  pix_class,
    input  logic [XW-1:0]             pix_x,
    input  logic [YW-1:0]             pix_y,
    output logic [NUM_CH*XW-1:0]      xmin_o,
    output logic [NUM_CH*XW-1:0]      xmax_o,
    output logic [NUM_CH*YW-1:0]      ymin_o,
    output logic [NUM_CH*YW-1:0]      ymax_o,
    output logic [NUM_CH*XW-1:0]      cx_o,
    output logic [NUM_CH*YW-1:0]      cy_o,
    output logic [NUM_CH*CNT_W-1:0]   count_o,
    output logic [NUM_CH-1:0]         found_o,
    output logic                      res_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int CW  = cls_w(NUM_CH);
    localparam int SXW = sum_w(XW, CNT_W);
    localparam int SYW = sum_w(YW, CNT_W);
    localparam int DW  = (SXW > SYW) ? SXW : SYW;
    localparam int LW  = $clog2(DW + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XW-1:0]    r_acc_xmin [NUM_CH], r_acc_xmax [NUM_CH];
    logic [YW-1:0]    r_acc_ymin [NUM_CH], r_acc_ymax [NUM_CH];
    logic [CNT_W-1:0] r_acc_cnt  [NUM_CH];
    logic [SXW-1:0]   r_acc_sx   [NUM_CH];
    logic [SYW-1:0]   r_acc_sy   [NUM_CH];

    logic [XW-1:0]    r_snp_xmin [NUM_CH], r_snp_xmax [NUM_CH];
    logic [YW-1:0]    r_snp_ymin [NUM_CH], r_snp_ymax [NUM_CH];
    logic [CNT_W-1:0] r_snp_cnt  [NUM_CH];
    logic [SXW-1:0]   r_snp_sx   [NUM_CH];
    logic [SYW-1:0]   r_snp_sy   [NUM_CH];

    logic [XW-1:0]    r_res_cx   [NUM_CH];
    logic [YW-1:0]    r_res_cy   [NUM_CH];

    state_e           r_state;
    logic [CW-1:0]    r_ch;
    logic             r_op;
    logic             r_res_valid;
    logic             r_overrun;

    logic             w_in_roi;
    logic             w_hit;
    logic [NUM_CH-1:0] w_sel;
    logic [NUM_CH-1:0] w_ok;
    logic             w_empty;
    logic             w_div_start;
    logic             w_div_done;
    logic [DW-1:0]    w_dividend;
    logic [LW-1:0]    w_len;
    logic [DW-1:0]    w_quo;

`ifdef BLOB_TRACKER_ROI_EN
    logic [XW-1:0] r_roi_x0, r_roi_x1;
    logic [YW-1:0] r_roi_y0, r_roi_y1;
    logic [XW-1:0] w_rx0, w_rx1;
    logic [YW-1:0] w_ry0, w_ry1;

    // The pixel coincident with frame_start already belongs to the new window.
    assign w_rx0 = frame_start ? roi_x0 : r_roi_x0;
    assign w_rx1 = frame_start ? roi_x1 : r_roi_x1;
    assign w_ry0 = frame_start ? roi_y0 : r_roi_y0;
    assign w_ry1 = frame_start ? roi_y1 : r_roi_y1;
    assign w_in_roi = (pix_x >= w_rx0) && (pix_x <= w_rx1) &&
                      (pix_y >= w_ry0) && (pix_y <= w_ry1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_roi_x0 <= '0;
            r_roi_x1 <= '0;
            r_roi_y0 <= '0;
            r_roi_y1 <= '0;
        end else if (frame_start) begin
            r_roi_x0 <= roi_x0;
            r_roi_x1 <= roi_x1;
            r_roi_y0 <= roi_y0;
            r_roi_y1 <= roi_y1;
        end
    end
`else
    assign w_in_roi = 1'b1;
`endif

    assign w_hit = pix_valid && pix_hit && w_in_roi;

    always_comb begin
        w_sel = '0;
        w_ok  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_sel[c] = w_hit && (pix_class == CW'(c));
            w_ok[c]  = (r_snp_cnt[c] != '0) && (r_snp_cnt[c] >= CNT_W'(MIN_PIX));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_acc_xmin[c] <= XW'(MIN_RST);
                r_acc_xmax[c] <= XW'(MAX_RST);
                r_acc_ymin[c] <= YW'(MIN_RST);
                r_acc_ymax[c] <= YW'(MAX_RST);
                r_acc_cnt[c]  <= '0;
                r_acc_sx[c]   <= '0;
                r_acc_sy[c]   <= '0;
                r_snp_xmin[c] <= XW'(MIN_RST);
                r_snp_xmax[c] <= XW'(MAX_RST);
                r_snp_ymin[c] <= YW'(MIN_RST);
                r_snp_ymax[c] <= YW'(MAX_RST);
                r_snp_cnt[c]  <= '0;
                r_snp_sx[c]   <= '0;
                r_snp_sy[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (frame_start) begin
                    r_snp_xmin[c] <= r_acc_xmin[c];
                    r_snp_xmax[c] <= r_acc_xmax[c];
                    r_snp_ymin[c] <= r_acc_ymin[c];
                    r_snp_ymax[c] <= r_acc_ymax[c];
                    r_snp_cnt[c]  <= r_acc_cnt[c];
                    r_snp_sx[c]   <= r_acc_sx[c];
                    r_snp_sy[c]   <= r_acc_sy[c];
                    r_acc_xmin[c] <= w_sel[c] ? pix_x : XW'(MIN_RST);
                    r_acc_xmax[c] <= w_sel[c] ? pix_x : XW'(MAX_RST);
                    r_acc_ymin[c] <= w_sel[c] ? pix_y : YW'(MIN_RST);
                    r_acc_ymax[c] <= w_sel[c] ? pix_y : YW'(MAX_RST);
                    r_acc_cnt[c]  <= w_sel[c] ? CNT_W'(1) : '0;
                    r_acc_sx[c]   <= w_sel[c] ? SXW'(pix_x) : '0;
                    r_acc_sy[c]   <= w_sel[c] ? SYW'(pix_y) : '0;
                end else if (w_sel[c]) begin
                    if (pix_x < r_acc_xmin[c]) r_acc_xmin[c] <= pix_x;
                    if (pix_x > r_acc_xmax[c]) r_acc_xmax[c] <= pix_x;
                    if (pix_y < r_acc_ymin[c]) r_acc_ymin[c] <= pix_y;
                    if (pix_y > r_acc_ymax[c]) r_acc_ymax[c] <= pix_y;
                    // Freezing sums with the count keeps sum/count a valid mean.
                    if (r_acc_cnt[c] != CNT_MAX) begin
                        r_acc_cnt[c] <= r_acc_cnt[c] + CNT_W'(1);
                        r_acc_sx[c]  <= r_acc_sx[c] + SXW'(pix_x);
                        r_acc_sy[c]  <= r_acc_sy[c] + SYW'(pix_y);
                    end
                end
            end
        end
    end

    assign w_empty     = (r_snp_cnt[r_ch] == '0);
    assign w_div_start = (r_state == ST_LOAD) && !w_empty && !frame_start;
    assign w_dividend  = r_op ? DW'(r_snp_sy[r_ch]) : DW'(r_snp_sx[r_ch]);
    assign w_len       = r_op ? LW'(SYW) : LW'(SXW);

    blob_seq_divider #(
        .DW (DW),
        .VW (CNT_W),
        .LW (LW)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_div_start),
        .len      (w_len),
        .dividend (w_dividend),
        .divisor  (r_snp_cnt[r_ch]),
        .done     (w_div_done),
        .quotient (w_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
            r_op    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_res_cx[c] <= '0;
                r_res_cy[c] <= '0;
            end
        end else if (frame_start) begin
            r_state <= ST_LOAD;
            r_ch    <= '0;
            r_op    <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD:  r_state <= w_empty ? ST_STORE : ST_DIV;
                ST_DIV:   if (w_div_done) r_state <= ST_STORE;
                ST_STORE: begin
                    if (w_empty) begin
                        r_res_cx[r_ch] <= '0;
                        r_res_cy[r_ch] <= '0;
                    end else if (!r_op) begin
                        r_res_cx[r_ch] <= XW'(w_quo);
                    end else begin
                        r_res_cy[r_ch] <= YW'(w_quo);
                    end
                    // An empty channel resolves both operands in a single STORE.
                    if (w_empty || r_op) begin
                        r_op <= 1'b0;
                        if (r_ch == CW'(NUM_CH - 1)) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_ch    <= r_ch + CW'(1);
                            r_state <= ST_LOAD;
                        end
                    end else begin
                        r_op    <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xmin_o      <= '0;
            xmax_o      <= '0;
            ymin_o      <= '0;
            ymax_o      <= '0;
            cx_o        <= '0;
            cy_o        <= '0;
            count_o     <= '0;
            found_o     <= '0;
            r_res_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun   <= frame_start && (r_state != ST_IDLE);
            r_res_valid <= (r_state == ST_DONE) && !frame_start;
            if ((r_state == ST_DONE) && !frame_start) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    xmin_o[c*XW +: XW]       <= w_ok[c] ? r_snp_xmin[c] : '0;
                    xmax_o[c*XW +: XW]       <= w_ok[c] ? r_snp_xmax[c] : '0;
                    ymin_o[c*YW +: YW]       <= w_ok[c] ? r_snp_ymin[c] : '0;
                    ymax_o[c*YW +: YW]       <= w_ok[c] ? r_snp_ymax[c] : '0;
                    cx_o[c*XW +: XW]         <= w_ok[c] ? r_res_cx[c]   : '0;
                    cy_o[c*YW +: YW]         <= w_ok[c] ? r_res_cy[c]   : '0;
                    count_o[c*CNT_W +: CNT_W] <= r_snp_cnt[c];
                    found_o[c]               <= w_ok[c];
                end
            end
        end
    end

    assign res_valid = r_res_valid;
    assign overrun   = r_overrun;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/blob_extent_tracker.md
Name: blob_extent_tracker

Overview:
- Parametrised successor to the fixed two-instance object analysers. Tracks NUM_CH binary object classes in one block.
- Fed by the binarised pixel stream in the CMOS_PCLK domain.
- Per class, per frame: accumulates bounding box (x/y min/max), pixel count and coordinate sums. At frame end, computes integer centroids with a shared sequential divider.
- Feeds the selector/overlay and UART reporting path.

Parameters:
- NUM_CH, 2, number of tracked classes (1..8)
- XW, 10, x coordinate width
- YW, 10, y coordinate width
- CNT_W, 19, pixel counter width (saturating)
- MIN_PIX, 16, minimum count for obj_found=1

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  async active-low reset
- frame_start  in  1  one-cycle pulse; closes previous frame, opens new one
- pix_valid  in  1  pixel qualifier
- pix_hit  in  1  pixel is foreground
- pix_class  in  $clog2(NUM_CH) (min 1)  class index of pixel
- pix_x  in  XW  current column
- pix_y  in  YW  current row
- xmin_o/xmax_o  out  NUM_CH*XW  flattened, channel 0 in LSBs
- ymin_o/ymax_o  out  NUM_CH*YW  flattened
- cx_o  out  NUM_CH*XW  centroid x
- cy_o  out  NUM_CH*YW  centroid y
- count_o  out  NUM_CH*CNT_W  foreground pixel count
- found_o  out  NUM_CH  count >= MIN_PIX
- res_valid  out  1  one-cycle pulse, all outputs updated
- busy  out  1  divide phase in progress
- overrun  out  1  one-cycle pulse, frame_start arrived while busy

Behaviour:
- Reset: all outputs, accumulators and FSM = 0/IDLE. Accumulator min registers reset to all-ones, max registers to 0.
- Accumulate:
  - Trigger: pix_valid && pix_hit && pix_class < NUM_CH. Other class values are ignored.
  - Action: update min/max of channel pix_class; count+1, saturating at 2^CNT_W-1 (sums frozen once count saturates); sum_x+=pix_x; sum_y+=pix_y.
  - Sum widths: XW+CNT_W and YW+CNT_W.
- frame_start:
  - Snapshots all accumulators into shadow registers, then reinitialises accumulators.
  - If pix_valid in the same cycle, that pixel is the first pixel of the new frame (it is loaded, not accumulated into the snapshot).
  - The first frame_start after reset snapshots empty accumulators; results are produced normally (all found=0).
- FSM states:
  - IDLE -> LOAD on frame_start.
  - LOAD: select channel ch, operand = sum_x or sum_y; 1 cycle.
  - DIV: restoring divide, one quotient bit per cycle, XW+CNT_W (or YW+CNT_W) cycles.
  - STORE: write quotient to result shadow; 1 cycle. Then next operand/channel -> LOAD, or after the last operand -> DONE.
  - DONE: copy result shadow to outputs, pulse res_valid; next cycle IDLE.
  - busy = 1 in all states except IDLE.
- Empty channel (count=0): divider skipped (LOAD->STORE, quotient 0). Outputs for that channel: min/max/cx/cy/count = 0, found=0. Applies equally when count < MIN_PIX except count_o reports the true count.
- Latency from frame_start to res_valid: sum over non-empty channels of (XW+CNT_W+2)+(YW+CNT_W+2), plus 2 cycles per empty channel, plus 1. Exact value is checked in the bench.
- Outputs hold between res_valid pulses.
- frame_start while busy: overrun pulses; the in-flight computation is aborted; the new snapshot is taken and the FSM restarts at LOAD ch0. Outputs keep the last completed results.
- Centroid = floor(sum/count), truncated to XW/YW (fits by construction).
- Async reset mid-divide: all state cleared, no res_valid.

Optional Feature:
- Macro: BLOB_TRACKER_ROI_EN.
- Defined: adds inputs roi_x0, roi_x1 (XW) and roi_y0, roi_y1 (YW), sampled on frame_start. Pixels outside [x0..x1]×[y0..y1] (inclusive) are ignored. If x0 > x1 or y0 > y1, every pixel is ignored.
- Undefined: no ROI ports; all pixels are eligible.

Decomposition:
- Shared package blob_tracker_pkg:
  - FSM state enum (IDLE, LOAD, DIV, STORE, DONE)
  - width helper functions (class index width, sum width)
  - reset constants for min/max
- Sub-module blob_seq_divider: start/done handshake, parametrised dividend/divisor width, restoring algorithm, returns quotient only.

Test Plan (NUM_CH=2, XW=YW=10, CNT_W=19, MIN_PIX=1 unless stated):
- Single hit class0 at (5,7), then frame_start -> ch0 xmin=xmax=5, ymin=ymax=7, cx=5, cy=7, count=1, found=1; ch1 all 0, found=0; one res_valid at the computed latency.
- Class1 filled square x10..19, y20..29 -> ch1 bounds 10/19/20/29, count=100, cx=14, cy=24; ch0 unchanged zero.
- MIN_PIX=16, class0 gets 15 hits -> found[0]=0, bounds/cx/cy 0, count_o=15.
- frame_start issued 20 cycles into DIV -> overrun=1 for one cycle, outputs unchanged until the next res_valid, which carries the second frame's correct values.
- pix_valid+pix_hit at (3,3) coincident with frame_start -> pixel absent from the closing frame's result, present in the next frame (count=1, cx=3).
- rst_n low during DIV -> outputs 0 immediately, busy=0, no res_valid; a following frame processes normally. With BLOB_TRACKER_ROI_EN and ROI 0..9×0..9, a hit at (15,15) is ignored.
